// File: rtl/flappy_pkg.sv
// Shared FlappyBox screen and obstacle constants, game state encoding and a BCD compare helper.
// No logic of its own; imported by the collision/score block, its interface and the score counter.
package flappy_pkg;

  localparam int T_W       = 29;
  localparam int T_H       = 480;
  localparam int S_Z       = 120;
  localparam int FLOOR_Y   = 479;
  localparam int RESPAWN_X = 670;
  localparam int BCD_W     = 12;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PLAY  = 2'd1,
    DYING = 2'd2,
    OVER  = 2'd3
  } state_e;

  // Most significant digit decides first.
  function automatic logic bcd_gt(input logic [BCD_W-1:0] a, input logic [BCD_W-1:0] b);
    if (a[11:8] != b[11:8]) return a[11:8] > b[11:8];
    if (a[7:4] != b[7:4]) return a[7:4] > b[7:4];
    return a[3:0] > b[3:0];
  endfunction

endpackage

// File: rtl/collision_score_if.sv
// Player/obstacle inputs and game status outputs of the collision/score block.
// master drives the geometry and button; slave is the collision_score block.
interface collision_score_if;
  import flappy_pkg::*;

  logic             btn_start;
  logic [9:0]       p_y;
  logic [9:0]       o1_x;
  logic [9:0]       o2_x;
  logic [9:0]       S_H1;
  logic [9:0]       S_H2;
  logic             playing;
  logic             game_over;
  logic             game_rst;
  logic             hit;
  logic             score_tick;
  logic [BCD_W-1:0] score_bcd;
  logic [BCD_W-1:0] hi_score_bcd;

  modport master (
    output btn_start, p_y, o1_x, o2_x, S_H1, S_H2,
    input  playing, game_over, game_rst, hit, score_tick, score_bcd, hi_score_bcd
  );

  modport slave (
    input  btn_start, p_y, o1_x, o2_x, S_H1, S_H2,
    output playing, game_over, game_rst, hit, score_tick, score_bcd, hi_score_bcd
  );

endinterface

// File: rtl/bcd_counter3.sv
// Three-digit BCD score counter: +1 or +2 per cycle, saturating at 999, with synchronous clear.
// Value and the incremented flag are registered, so both appear one edge after the request.
module bcd_counter3
  import flappy_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             clr_i,
  input  logic             inc1_i,
  input  logic             inc2_i,
  output logic [BCD_W-1:0] value_o,
  output logic             incr_o
);

  localparam logic [BCD_W-1:0] MAX_BCD = 12'h999;

  logic [BCD_W-1:0] value_q, value_d;
  logic             incr_q, incr_d;

  function automatic logic [BCD_W-1:0] bcd_inc(input logic [BCD_W-1:0] v);
    logic [3:0] d2, d1, d0;
    {d2, d1, d0} = v;
    if (d0 != 4'd9) begin
      d0 = d0 + 4'd1;
    end else begin
      d0 = 4'd0;
      if (d1 != 4'd9) begin
        d1 = d1 + 4'd1;
      end else begin
        d1 = 4'd0;
        d2 = d2 + 4'd1;
      end
    end
    return {d2, d1, d0};
  endfunction

  always_comb begin
    logic [BCD_W-1:0] once;
    once    = bcd_inc(value_q);
    value_d = value_q;
    incr_d  = 1'b0;
    if (clr_i) begin
      value_d = '0;
    end else if ((inc1_i || inc2_i) && value_q != MAX_BCD) begin
      incr_d  = 1'b1;
      // A +2 from 998 stops at 999 rather than wrapping.
      value_d = (inc2_i && once != MAX_BCD) ? bcd_inc(once) : once;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      value_q <= '0;
      incr_q  <= 1'b0;
    end else begin
      value_q <= value_d;
      incr_q  <= incr_d;
    end
  end

  assign value_o = value_q;
  assign incr_o  = incr_q;

endmodule

// File: rtl/collision_score.sv
// FlappyBox collision/score/game FSM; inputs staged once, outputs registered: 2-cycle latency, no backpressure.
// HIGH_SCORE_EN builds the best-score register; otherwise hi_score_bcd is tied to zero.
module collision_score
  import flappy_pkg::*;
#(
  parameter int P_X      = 200,
  parameter int P_W      = 20,
  parameter int P_H      = 20,
  parameter int HIT_HOLD = 25000000
) (
  input logic              clk,
  input logic              reset,
  collision_score_if.slave bus
);

  localparam int CW = ($clog2(HIT_HOLD) < 1) ? 1 : $clog2(HIT_HOLD);

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            game_rst_q, game_rst_d;
  logic            hit_q, hit_d;
  logic [9:0]      py_q, o1x_q, o2x_q, sh1_q, sh2_q;
  logic [9:0]      o1x_prev_q, o2x_prev_q;
  logic            btn_q, btn_prev_q;
  logic            btn_rise, hit_cond, pass1, pass2;
  logic            score_clr, inc1, inc2;
  logic [BCD_W-1:0] score;

  // Column spans [o_x-28, o_x]; the left edge is signed so small o_x cannot wrap.
  function automatic logic coll(input logic [9:0] ox, input logic [9:0] sh, input logic [9:0] py);
    logic signed [11:0] left;
    logic               xov, yout;
    left = $signed({2'b00, ox}) - $signed(12'(T_W - 1));
    xov  = ({1'b0, ox} >= 11'(P_X)) && (left <= $signed(12'(P_X + P_W - 1)));
    yout = ({1'b0, py} < {1'b0, sh}) ||
           (({1'b0, py} + 11'(P_H - 1)) > ({1'b0, sh} + 11'(S_Z - 2)));
    return xov && yout;
  endfunction

  assign btn_rise = btn_q && !btn_prev_q;
  assign hit_cond = coll(o1x_q, sh1_q, py_q) || coll(o2x_q, sh2_q, py_q) ||
                    (({1'b0, py_q} + 11'(P_H - 1)) >= 11'(FLOOR_Y));
  assign pass1    = (o1x_prev_q >= 10'(P_X)) && (o1x_q < 10'(P_X));
  assign pass2    = (o2x_prev_q >= 10'(P_X)) && (o2x_q < 10'(P_X));

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    game_rst_d = 1'b0;
    hit_d      = 1'b0;
    score_clr  = 1'b0;
    inc1       = 1'b0;
    inc2       = 1'b0;
    unique case (state_q)
      IDLE: if (btn_rise) begin
        state_d    = PLAY;
        game_rst_d = 1'b1;
        score_clr  = 1'b1;
      end
      PLAY: if (hit_cond) begin
        state_d = DYING;
        hit_d   = 1'b1;
        cnt_d   = CW'(HIT_HOLD - 1);
      end else begin
        inc1 = pass1 ^ pass2;
        inc2 = pass1 & pass2;
      end
      DYING: if (cnt_q == '0) state_d = OVER;
             else cnt_d = cnt_q - CW'(1);
      OVER: if (btn_rise) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      game_rst_q <= 1'b0;
      hit_q      <= 1'b0;
      py_q       <= '0;
      o1x_q      <= '0;
      o2x_q      <= '0;
      sh1_q      <= '0;
      sh2_q      <= '0;
      o1x_prev_q <= '0;
      o2x_prev_q <= '0;
      btn_q      <= 1'b0;
      btn_prev_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      game_rst_q <= game_rst_d;
      hit_q      <= hit_d;
      py_q       <= bus.p_y;
      o1x_q      <= bus.o1_x;
      o2x_q      <= bus.o2_x;
      sh1_q      <= bus.S_H1;
      sh2_q      <= bus.S_H2;
      o1x_prev_q <= o1x_q;
      o2x_prev_q <= o2x_q;
      btn_q      <= bus.btn_start;
      btn_prev_q <= btn_q;
    end
  end

  bcd_counter3 u_score (
    .clk     (clk),
    .reset   (reset),
    .clr_i   (score_clr),
    .inc1_i  (inc1),
    .inc2_i  (inc2),
    .value_o (score),
    .incr_o  (bus.score_tick)
  );

`ifdef HIGH_SCORE_EN
  logic [BCD_W-1:0] hi_q;
  always_ff @(posedge clk) begin
    if (reset) hi_q <= '0;
    else if (state_q == DYING && cnt_q == '0 && bcd_gt(score, hi_q)) hi_q <= score;
  end
  assign bus.hi_score_bcd = hi_q;
`else
  assign bus.hi_score_bcd = '0;
`endif

  assign bus.playing   = (state_q == PLAY);
  assign bus.game_over = (state_q == OVER);
  assign bus.game_rst  = game_rst_q;
  assign bus.hit       = hit_q;
  assign bus.score_bcd = score;

endmodule

// File: tb/tb_collision_score.sv
// Randomized and directed stimulus for collision_score, checked every cycle against a game-level model.
module tb_collision_score;

  localparam int HOLD = 10;
  localparam int M_IDLE = 0, M_PLAY = 1, M_DYING = 2, M_OVER = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  collision_score_if bus ();

  collision_score #(.P_X(200), .P_W(20), .P_H(20), .HIT_HOLD(HOLD)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model state: plain integer score and game phase.
  int m_state, m_score, m_hi, m_left;
  bit m_rst, m_hit, m_tick;
  int s_py, s_o1, s_o2, s_sh1, s_sh2, p_o1, p_o2;
  bit s_btn, p_btn;

  function automatic bit m_coll(input int ox, input int sh, input int py);
    return (ox >= 200) && (ox - 28 <= 219) && ((py < sh) || (py + 19 > sh + 118));
  endfunction

  function automatic int to_bcd(input int v);
    return (v / 100) * 256 + ((v / 10) % 10) * 16 + (v % 10);
  endfunction

  task automatic model_edge();
    bit rise, hitc;
    int np;
    if (reset) begin
      m_state = M_IDLE; m_score = 0; m_hi = 0; m_left = 0;
      m_rst = 0; m_hit = 0; m_tick = 0;
      s_py = 0; s_o1 = 0; s_o2 = 0; s_sh1 = 0; s_sh2 = 0; s_btn = 0;
      p_o1 = 0; p_o2 = 0; p_btn = 0;
      return;
    end
    m_rst = 0; m_hit = 0; m_tick = 0;
    rise = s_btn && !p_btn;
    hitc = m_coll(s_o1, s_sh1, s_py) || m_coll(s_o2, s_sh2, s_py) || (s_py + 19 >= 479);
    np   = int'(p_o1 >= 200 && s_o1 < 200) + int'(p_o2 >= 200 && s_o2 < 200);
    case (m_state)
      M_IDLE: if (rise) begin m_state = M_PLAY; m_rst = 1; m_score = 0; end
      M_PLAY: begin
        if (hitc) begin
          m_state = M_DYING; m_hit = 1; m_left = HOLD;
        end else if (np > 0 && m_score < 999) begin
          m_tick  = 1;
          m_score = (m_score + np > 999) ? 999 : m_score + np;
        end
      end
      M_DYING: begin
        m_left--;
        if (m_left == 0) begin
          m_state = M_OVER;
`ifdef HIGH_SCORE_EN
          if (m_score > m_hi) m_hi = m_score;
`endif
        end
      end
      default: if (rise) m_state = M_IDLE;
    endcase
    p_o1 = s_o1; p_o2 = s_o2; p_btn = s_btn;
    s_py = int'(bus.p_y); s_o1 = int'(bus.o1_x); s_o2 = int'(bus.o2_x);
    s_sh1 = int'(bus.S_H1); s_sh2 = int'(bus.S_H2); s_btn = bus.btn_start;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("playing",    int'(bus.playing),    int'(m_state == M_PLAY));
    check("game_over",  int'(bus.game_over),  int'(m_state == M_OVER));
    check("game_rst",   int'(bus.game_rst),   int'(m_rst));
    check("hit",        int'(bus.hit),        int'(m_hit));
    check("score_tick", int'(bus.score_tick), int'(m_tick));
    check("score_bcd",  int'(bus.score_bcd),  to_bcd(m_score));
    check("hi_score",   int'(bus.hi_score_bcd), to_bcd(m_hi));
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic press();
    bus.btn_start = 1'b1; steps(2);
    bus.btn_start = 1'b0; steps(2);
  endtask

  task automatic passes(input int n, input bit both);
    for (int i = 0; i < n; i++) begin
      bus.o1_x = 10'd200; if (both) bus.o2_x = 10'd200; step();
      bus.o1_x = 10'd199; if (both) bus.o2_x = 10'd199; step();
    end
    bus.o1_x = 10'd600; bus.o2_x = 10'd600; step();
  endtask

  task automatic safe_lane();
    bus.p_y = 10'd250; bus.S_H1 = 10'd200; bus.S_H2 = 10'd200;
    bus.o1_x = 10'd600; bus.o2_x = 10'd600;
  endtask

  // From OVER: back to IDLE, start, score n, die on the floor.
  task automatic play_game(input int n);
    safe_lane();
    press(); press();
    passes(n, 1'b0);
    bus.p_y = 10'd470; steps(HOLD + 4);
    bus.p_y = 10'd250;
  endtask

  initial begin
    int r_o1, r_o2;
    bus.btn_start = 1'b0;
    safe_lane();
    steps(3);
    reset = 1'b0;
    steps(2);

    // Start game: game_rst two edges after the press.
    bus.btn_start = 1'b1; steps(3);
    bus.btn_start = 1'b0; step();

    // Upper/lower column edges against obstacle 1.
    bus.S_H1 = 10'd100; bus.o1_x = 10'd210;
    bus.p_y = 10'd150; steps(3);
    bus.p_y = 10'd199; steps(3);
    bus.p_y = 10'd200; steps(HOLD + 4);

    // Floor boundary with obstacles far away.
    safe_lane();
    press(); press();
    bus.p_y = 10'd459; steps(3);
    bus.p_y = 10'd460; steps(HOLD + 4);

    play_game(12);
    play_game(7);

    // Long game: single pass, respawn jump, carry chains, saturation.
    safe_lane();
    press(); press();
    passes(1, 1'b0);
    bus.o1_x = 10'd0; step();
    bus.o1_x = 10'd670; steps(2);
    passes(98, 1'b0);
    passes(1, 1'b0);
    passes(450, 1'b1);
    passes(3, 1'b0);
    passes(2, 1'b1);

    // Restart and check hit beats a same-cycle pass, then a double pass.
    bus.p_y = 10'd470; steps(HOLD + 4);
    safe_lane();
    press(); press();
    passes(2, 1'b1);
    bus.o2_x = 10'd200; step();
    bus.o2_x = 10'd199; bus.o1_x = 10'd210; bus.S_H1 = 10'd100; step();
    steps(HOLD + 4);

    // Reset in the middle of a game.
    safe_lane();
    press(); press();
    passes(3, 1'b0);
    reset = 1'b1; step();
    reset = 1'b0; steps(2);

    // Random play.
    r_o1 = 400; r_o2 = 670;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 5) == 0) bus.btn_start = ~bus.btn_start;
      if ($urandom_range(0, 1) == 0) bus.p_y = 10'($urandom_range(0, 479));
      else bus.p_y = 10'(int'(bus.S_H1) + $urandom_range(0, 99));
      r_o1 = (r_o1 < 4) ? 670 : r_o1 - int'($urandom_range(0, 3));
      r_o2 = (r_o2 < 4) ? 670 : r_o2 - int'($urandom_range(0, 3));
      bus.o1_x = 10'(r_o1);
      bus.o2_x = 10'(r_o2);
      if ($urandom_range(0, 40) == 0) bus.S_H1 = 10'($urandom_range(0, 340));
      if ($urandom_range(0, 40) == 0) bus.S_H2 = 10'($urandom_range(0, 340));
      reset = ($urandom_range(0, 699) == 0);
      step();
    end
    reset = 1'b0;
    steps(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
